// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates fetch/data ports onto one memory bus and decodes PSW/EXC_RET/alignment.
// Optional MEM_TIMEOUT_EN: aborts a memory cycle with a fault after TIMEOUT cycles without mem_rdy_i.
module mem_access_ctrl #(
   parameter int              WORD     = 16,
   parameter logic [WORD-1:0] PSW_ADDR = 16'hFFFC,
   parameter logic [WORD-1:0] EXC_RET  = 16'hFFFF,
   parameter int              TIMEOUT  = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [WORD-1:0] if_addr_i,
   output logic            if_ack_o,
   output logic [WORD-1:0] if_rdata_o,
   output logic            if_fault_o,
   output logic            exc_ret_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic            d_byte_i,
   input  logic [WORD-1:0] d_addr_i,
   input  logic [WORD-1:0] d_wdata_i,
   output logic            d_ack_o,
   output logic [WORD-1:0] d_rdata_o,
   output logic            d_fault_o,
   output logic            mem_en_o,
   output logic            mem_we_o,
   output logic [1:0]      mem_sel_o,
   output logic [WORD-1:0] mem_addr_o,
   output logic [WORD-1:0] mem_wdata_o,
   input  logic [WORD-1:0] mem_rdata_i,
   input  logic            mem_rdy_i,
   input  logic [WORD-1:0] psw_i,
   output logic            psw_we_o,
   output logic [WORD-1:0] psw_wdata_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_RESP} state_t;

   state_t          state_reg;
   logic            port_reg;   // 1 = data port owns the current access
   logic            byte_reg;
   logic            lane_reg;

   logic            sel_data;
   logic            req_any;
   logic [WORD-1:0] req_addr;
   logic            psw_hit;
   logic            dec_fault;
   logic            dec_exc;
   logic            dec_psw;
   logic            dec_mem;
   logic [1:0]      sel_mem;
   logic [WORD-1:0] wdata_mem;
   logic [WORD-1:0] rdata_fmt;
   logic            mem_tmo;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("TIMEOUT must be at least 1");
   end

   // Decode the request about to be granted so the grant edge already selects MEM or RESP.
   always_comb begin
      sel_data  = d_req_i;
      req_any   = d_req_i | if_req_i;
      req_addr  = sel_data ? d_addr_i : if_addr_i;
      psw_hit   = (req_addr[WORD-1:1] == PSW_ADDR[WORD-1:1]);
      dec_fault = 1'b0;
      dec_exc   = 1'b0;
      dec_psw   = 1'b0;
      if (sel_data) begin
         dec_fault = (!d_byte_i && req_addr[0]) || (psw_hit && d_byte_i);
         dec_psw   = psw_hit && !dec_fault;
      end else begin
         dec_exc   = (req_addr == EXC_RET);
         dec_fault = !dec_exc && (req_addr[0] || psw_hit);
      end
      dec_mem = !(dec_fault || dec_exc || dec_psw);

      if (!sel_data || !d_byte_i) begin
         sel_mem = 2'b11;
      end else begin
         sel_mem = req_addr[0] ? 2'b10 : 2'b01;
      end

      wdata_mem = '0;
      if (sel_data && d_we_i) begin
         wdata_mem = d_byte_i ? {2{d_wdata_i[7:0]}} : d_wdata_i;
      end
   end

   always_comb begin
      rdata_fmt = mem_rdata_i;
      if (byte_reg) begin
         rdata_fmt = {{(WORD-8){1'b0}}, lane_reg ? mem_rdata_i[WORD-1:WORD-8] : mem_rdata_i[7:0]};
      end
      if (mem_we_o) begin
         rdata_fmt = '0;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] wait_cnt_reg;

   // Held at zero outside MEM, so every memory cycle starts counting from zero.
   always_ff @(posedge clk_i) begin
      if (rst_i || state_reg != ST_MEM) begin
         wait_cnt_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
   end

   assign mem_tmo = !mem_rdy_i && (wait_cnt_reg == CNT_LAST);
`else
   assign mem_tmo = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         port_reg    <= 1'b0;
         byte_reg    <= 1'b0;
         lane_reg    <= 1'b0;
         if_ack_o    <= 1'b0;
         if_rdata_o  <= '0;
         if_fault_o  <= 1'b0;
         exc_ret_o   <= 1'b0;
         d_ack_o     <= 1'b0;
         d_rdata_o   <= '0;
         d_fault_o   <= 1'b0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_sel_o   <= 2'b00;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         psw_we_o    <= 1'b0;
         psw_wdata_o <= '0;
      end else begin
         // Response outputs are single-cycle pulses; only the RESP entry sets them.
         if_ack_o    <= 1'b0;
         if_rdata_o  <= '0;
         if_fault_o  <= 1'b0;
         exc_ret_o   <= 1'b0;
         d_ack_o     <= 1'b0;
         d_rdata_o   <= '0;
         d_fault_o   <= 1'b0;
         psw_we_o    <= 1'b0;
         psw_wdata_o <= '0;

         case (state_reg)
            ST_IDLE: begin
               if (req_any) begin
                  port_reg <= sel_data;
                  byte_reg <= sel_data & d_byte_i;
                  lane_reg <= req_addr[0];
                  if (dec_mem) begin
                     state_reg   <= ST_MEM;
                     mem_en_o    <= 1'b1;
                     mem_we_o    <= sel_data & d_we_i;
                     mem_sel_o   <= sel_mem;
                     mem_addr_o  <= req_addr;
                     mem_wdata_o <= wdata_mem;
                  end else begin
                     state_reg <= ST_RESP;
                     if (sel_data) begin
                        d_ack_o   <= 1'b1;
                        d_fault_o <= dec_fault;
                        if (dec_psw && d_we_i) begin
                           psw_we_o    <= 1'b1;
                           psw_wdata_o <= d_wdata_i;
                        end
                        if (dec_psw && !d_we_i) begin
                           d_rdata_o <= psw_i;
                        end
                     end else begin
                        if_ack_o   <= 1'b1;
                        if_fault_o <= dec_fault;
                        exc_ret_o  <= dec_exc;
                     end
                  end
               end
            end
            ST_MEM: begin
               if (mem_rdy_i || mem_tmo) begin
                  state_reg   <= ST_RESP;
                  mem_en_o    <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_sel_o   <= 2'b00;
                  mem_addr_o  <= '0;
                  mem_wdata_o <= '0;
                  if (port_reg) begin
                     d_ack_o   <= 1'b1;
                     d_fault_o <= mem_tmo;
                     d_rdata_o <= mem_tmo ? '0 : rdata_fmt;
                  end else begin
                     if_ack_o   <= 1'b1;
                     if_fault_o <= mem_tmo;
                     if_rdata_o <= mem_tmo ? '0 : rdata_fmt;
                  end
               end
            end
            ST_RESP: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: reference model predicts responses and bus cycles,
// a monitor and a memory responder compare the DUT against them.
module tb_mem_access_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [15:0] if_addr_i;
   logic        if_ack_o;
   logic [15:0] if_rdata_o;
   logic        if_fault_o;
   logic        exc_ret_o;
   logic        d_req_i;
   logic        d_we_i;
   logic        d_byte_i;
   logic [15:0] d_addr_i;
   logic [15:0] d_wdata_i;
   logic        d_ack_o;
   logic [15:0] d_rdata_o;
   logic        d_fault_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [1:0]  mem_sel_o;
   logic [15:0] mem_addr_o;
   logic [15:0] mem_wdata_o;
   logic [15:0] mem_rdata_i;
   logic        mem_rdy_i;
   logic [15:0] psw_i;
   logic        psw_we_o;
   logic [15:0] psw_wdata_o;

   always #5 clk_i = ~clk_i;

   mem_access_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
      .if_rdata_o(if_rdata_o), .if_fault_o(if_fault_o), .exc_ret_o(exc_ret_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_byte_i(d_byte_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_fault_o(d_fault_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_rdy_i(mem_rdy_i),
      .psw_i(psw_i), .psw_we_o(psw_we_o), .psw_wdata_o(psw_wdata_o)
   );

   typedef struct {
      bit          port;
      bit          fault;
      bit          exc;
      bit          chk_rdata;
      logic [15:0] rdata;
      bit          psw_we;
      logic [15:0] psw_wdata;
   } resp_t;

   typedef struct {
      logic [15:0] addr;
      bit          we;
      logic [1:0]  sel;
      logic [15:0] wdata;
      int          waits;
   } bus_t;

   resp_t       exp_q[$];
   bus_t        bus_q[$];
   logic [15:0] ref_mem [0:32767];
   logic [15:0] bus_mem [0:32767];
   logic [15:0] psw_val;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   // Reference model: address rules and byte-lane arithmetic on a flat word memory.
   task automatic predict(input bit is_data, we, byt, input logic [15:0] addr, wdata,
                          output resp_t e, output bit m, output bus_t b);
      int  word, sh, idx;
      bit  in_psw;
      e.port = is_data; e.fault = 0; e.exc = 0; e.chk_rdata = 0;
      e.rdata = 0; e.psw_we = 0; e.psw_wdata = 0;
      b.addr = addr; b.we = we; b.sel = 2'b11; b.wdata = wdata; b.waits = 0;
      m      = 0;
      idx    = int'(addr) / 2;
      sh     = 8 * (int'(addr) % 2);
      word   = int'(ref_mem[idx]);
      in_psw = (idx == 16'hFFFC / 2);
      if (!is_data) begin
         if (addr == 16'hFFFF) e.exc = 1;
         else if (sh != 0 || in_psw) e.fault = 1;
         else begin m = 1; e.chk_rdata = 1; e.rdata = 16'(word); end
      end else if ((!byt && sh != 0) || (in_psw && byt)) begin
         e.fault = 1;
      end else if (in_psw) begin
         if (we) begin e.psw_we = 1; e.psw_wdata = wdata; end
         else begin e.chk_rdata = 1; e.rdata = psw_val; end
      end else begin
         m = 1;
         if (byt) begin
            b.sel   = (sh != 0) ? 2'b10 : 2'b01;
            b.wdata = 16'((int'(wdata) % 256) * 257);
         end
         if (!we) begin
            e.chk_rdata = 1;
            e.rdata = byt ? 16'((word >> sh) % 256) : 16'(word);
         end else if (byt) begin
            ref_mem[idx] = 16'((word & ~(255 << sh)) | ((int'(wdata) % 256) << sh));
         end else begin
            ref_mem[idx] = wdata;
         end
      end
   endtask

   task automatic run_req(input bit is_data, we, byt, input logic [15:0] addr, wdata,
                          input int exp_lat, input string name);
      int n = 0;
      bit got = 0;
      if (is_data) begin
         d_req_i = 1; d_we_i = we; d_byte_i = byt; d_addr_i = addr; d_wdata_i = wdata;
      end else begin
         if_req_i = 1; if_addr_i = addr;
      end
      while (!got && n < 300) begin
         @(posedge clk_i); n++;
         @(negedge clk_i);
         got = is_data ? d_ack_o : if_ack_o;
      end
      check({name, "_latency"}, got ? n : -1, exp_lat);
      d_req_i = 0; if_req_i = 0;
      @(posedge clk_i); @(negedge clk_i);
   endtask

   task automatic issue(input bit is_data, we, byt, input logic [15:0] addr, wdata,
                        input int waits, input string name);
      resp_t e;
      bus_t  b;
      bit    m;
      psw_val = 16'($urandom);
      psw_i   = psw_val;
      predict(is_data, we, byt, addr, wdata, e, m, b);
      b.waits = waits;
      exp_q.push_back(e);
      if (m) bus_q.push_back(b);
      run_req(is_data, we, byt, addr, wdata, m ? 2 + waits : 1, name);
   endtask

   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk_i);
         if (if_ack_o && d_ack_o) begin
            check("dual_ack", 1, 0);
         end else if (if_ack_o || d_ack_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("ack_port", d_ack_o, e.port);
               check("fault", d_ack_o ? d_fault_o : if_fault_o, e.fault);
               check("exc_ret", exc_ret_o, e.exc);
               check("psw_we", psw_we_o, e.psw_we);
               if (e.psw_we) check("psw_wdata", psw_wdata_o, e.psw_wdata);
               if (e.chk_rdata) check("rdata", d_ack_o ? d_rdata_o : if_rdata_o, e.rdata);
            end
         end else begin
            check("idle_strobes", {if_fault_o, d_fault_o, exc_ret_o, psw_we_o}, 0);
         end
         if (!mem_en_o) check("mem_bus_idle", {mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o}, 0);
      end
   end

   initial begin : responder
      bus_t b;
      bit   active = 0;
      int   cnt = 0;
      int   idx;
      mem_rdy_i   = 0;
      mem_rdata_i = 0;
      forever begin
         @(negedge clk_i);
         mem_rdy_i = 0;
         if (!mem_en_o) begin
            active      = 0;
            mem_rdata_i = 16'($urandom);
         end else begin
            if (!active) begin
               if (bus_q.size() == 0) begin
                  check("unexpected_mem_cycle", 1, 0);
                  b.waits = 0;
               end else begin
                  b = bus_q.pop_front();
                  check("mem_addr", mem_addr_o, b.addr);
                  check("mem_we", mem_we_o, b.we);
                  check("mem_sel", mem_sel_o, b.sel);
                  if (b.we) check("mem_wdata", mem_wdata_o, b.wdata);
               end
               active = 1;
               cnt    = 0;
            end
            if (cnt >= b.waits) begin
               idx         = int'(mem_addr_o) / 2;
               mem_rdy_i   = 1;
               mem_rdata_i = bus_mem[idx];
               if (mem_we_o) begin
                  if (mem_sel_o[0]) bus_mem[idx][7:0]  = mem_wdata_o[7:0];
                  if (mem_sel_o[1]) bus_mem[idx][15:8] = mem_wdata_o[15:8];
               end
               active = 0;
            end else begin
               mem_rdata_i = 16'($urandom);
               cnt++;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish, required finish before 100000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      resp_t       e;
      bus_t        b;
      bit          m, got, rd, rwe, rby;
      int          n, d_n, i_n, hold;
      logic [15:0] ra;

      for (int i = 0; i < 32768; i++) begin
         ref_mem[i] = 16'(i * 40503) ^ 16'h3C5A;
         bus_mem[i] = ref_mem[i];
      end
      rst_i = 1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_byte_i = 0;
      d_addr_i = 0; d_wdata_i = 0; psw_i = 0; psw_val = 0;
      repeat (3) @(negedge clk_i);
      check("rst_if_outputs", {if_ack_o, if_fault_o, exc_ret_o, if_rdata_o}, 0);
      check("rst_d_outputs", {d_ack_o, d_fault_o, d_rdata_o}, 0);
      check("rst_mem_outputs", {mem_en_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o}, 0);
      check("rst_psw_outputs", {psw_we_o, psw_wdata_o}, 0);
      rst_i = 0;
      @(negedge clk_i);

      ref_mem[16'h0100 / 2] = 16'hBEEF; bus_mem[16'h0100 / 2] = 16'hBEEF;
      issue(0, 0, 0, 16'h0100, 16'h0000, 0, "t1_fetch");

      ref_mem[16'h0202 / 2] = 16'hA55A; bus_mem[16'h0202 / 2] = 16'hA55A;
      issue(1, 0, 1, 16'h0203, 16'h0000, 0, "t2_byte_hi");
      issue(1, 0, 1, 16'h0202, 16'h0000, 1, "t2_byte_lo");
      issue(1, 1, 0, 16'h0301, 16'h1234, 0, "t3_misaligned_write");

      // Simultaneous requests: data (PSW write) wins, fetch is granted after the RESP cycle.
      psw_val = 16'h1111; psw_i = psw_val;
      predict(1, 1, 0, 16'hFFFC, 16'h0007, e, m, b);
      exp_q.push_back(e);
      predict(0, 0, 0, 16'h0010, 16'h0000, e, m, b);
      b.waits = 0;
      exp_q.push_back(e); bus_q.push_back(b);
      d_req_i = 1; d_we_i = 1; d_byte_i = 0; d_addr_i = 16'hFFFC; d_wdata_i = 16'h0007;
      if_req_i = 1; if_addr_i = 16'h0010;
      n = 0; d_n = -1; i_n = -1;
      while (i_n < 0 && n < 50) begin
         @(posedge clk_i); n++;
         @(negedge clk_i);
         if (d_ack_o) begin d_n = n; d_req_i = 0; end
         if (if_ack_o) begin i_n = n; if_req_i = 0; end
      end
      check("t4_psw_latency", d_n, 1);
      check("t4_fetch_latency", i_n, 4);
      d_req_i = 0; if_req_i = 0;
      @(posedge clk_i); @(negedge clk_i);

      issue(0, 0, 0, 16'hFFFF, 16'h0000, 0, "t5_exc_ret");

      // Stalled fetch, then reset mid-wait; the held request is re-arbitrated afterwards.
`ifdef MEM_TIMEOUT_EN
      hold = 5;
`else
      hold = 100;
`endif
      predict(0, 0, 0, 16'h0120, 16'h0000, e, m, b);
      exp_q.push_back(e);
      b.waits = 1000000; bus_q.push_back(b);
      b.waits = 0;       bus_q.push_back(b);
      if_req_i = 1; if_addr_i = 16'h0120;
      got = 0;
      repeat (hold) begin
         @(posedge clk_i); @(negedge clk_i);
         if (if_ack_o) got = 1;
      end
      check("t5_no_ack_while_waiting", got, 0);
      check("t5_mem_en_while_waiting", mem_en_o, 1);
      rst_i = 1;
      @(posedge clk_i); #1;
      check("t5_mem_en_after_rst", mem_en_o, 0);
      check("t5_no_ack_after_rst", if_ack_o, 0);
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 0;
      run_req(0, 0, 0, 16'h0120, 16'h0000, 2, "t5_rearbitrated");

`ifdef MEM_TIMEOUT_EN
      predict(0, 0, 0, 16'h0140, 16'h0000, e, m, b);
      e.fault = 1; e.chk_rdata = 1; e.rdata = 16'h0000;
      exp_q.push_back(e);
      b.waits = 1000000; bus_q.push_back(b);
      run_req(0, 0, 0, 16'h0140, 16'h0000, 17, "t6_timeout");
`endif

      for (int i = 0; i < 250; i++) begin
         rd  = 1'($urandom_range(0, 1));
         rwe = rd & 1'($urandom_range(0, 1));
         rby = rd & 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) ra = 16'hFFF8 + 16'($urandom_range(0, 7));
         else ra = 16'($urandom_range(0, 511));
         issue(rd, rwe, rby, ra, 16'($urandom), int'($urandom_range(0, 3)), "rand");
      end

      repeat (5) @(negedge clk_i);
      check("resp_queue_drained", exp_q.size(), 0);
      check("bus_queue_drained", bus_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
